// File: rtl/multicycle_core.sv
// Multicycle processor for the 16-bit instruction set: a control FSM drives one
// shared instruction/data memory port with a req/ready handshake.
module multicycle_core #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  retired,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [2:0] FN_NOP   = 3'b111;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] rf_q [8];

    logic                  rf_we;
    logic [2:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    logic [3:0]            opcode;
    logic [2:0]            rs, rt, rd, funct;
    logic [DATA_WIDTH-1:0] imm_data;
    logic [ADDR_WIDTH-1:0] imm_addr;
    logic [ADDR_WIDTH-1:0] data_addr;

    assign opcode    = ir_q[15:12];
    assign rs        = ir_q[11:9];
    assign rt        = ir_q[8:6];
    assign rd        = ir_q[5:3];
    assign funct     = ir_q[2:0];
    assign imm_data  = DATA_WIDTH'($signed(ir_q[5:0]));
    assign imm_addr  = ADDR_WIDTH'($signed(ir_q[5:0]));
    assign data_addr = ADDR_WIDTH'(alu_q);

    assign pc      = pc_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

    function automatic logic [DATA_WIDTH-1:0] alu_op(input logic [2:0]            f,
                                                     input logic [DATA_WIDTH-1:0] x,
                                                     input logic [DATA_WIDTH-1:0] y);
        case (f)
            3'b000:  return x + y;
            3'b001:  return x - y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            3'b100:  return x ^ y;
            3'b101:  return ~(x | y);
            3'b110:  return {{(DATA_WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            default: return '0;
        endcase
    endfunction

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retired   = 1'b0;

        case (state_q)
            ST_START: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = ST_DECODE;
                end
            end

            // r0 is never written, so it reads back as its reset value of zero.
            ST_DECODE: begin
                a_d = rf_q[rs];
                b_d = rf_q[rt];
                case (opcode)
                    OP_HALT: state_d = ST_HALT;
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J:
                        state_d = ST_EXECUTE;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end

            ST_EXECUTE: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_d   = alu_op(funct, a_q, b_q);
                        state_d = ST_WRITEBACK;
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + imm_data;
                        state_d = ST_WRITEBACK;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_data;
                        state_d = ST_MEMORY;
                    end
                    OP_BEQ, OP_BNE: begin
                        if ((a_q == b_q) == (opcode == OP_BEQ))
                            pc_d = pc_q + imm_addr;
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_J: begin
                        pc_d    = (pc_q & ~ADDR_WIDTH'(12'hFFF)) | ADDR_WIDTH'(ir_q[11:0]);
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end

            ST_MEMORY: begin
                mem_req   = 1'b1;
                mem_we    = (opcode == OP_SW);
                mem_addr  = data_addr;
                mem_wdata = b_q;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WRITEBACK;
                    end
                end
            end

            ST_WRITEBACK: begin
                retired = 1'b1;
                state_d = ST_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        rf_we    = (funct != FN_NOP);
                        rf_waddr = rd;
                        rf_wdata = alu_q;
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = alu_q;
                    end
                    default: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = mdr_q;
                    end
                endcase
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_START;
        endcase
    end

    // NOTE: the register file must power up as all zeros, so it is built from
    // resettable flops rather than an inferred RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_START;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            if (rf_we && (rf_waddr != 3'd0)) rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: a 16/16 core with a stallable memory model
// and a 32/20 core that starts at the top of its address space.
module tb_multicycle_core;

    logic        clock, reset_n;
    logic        m_req, m_we, m_ready, retired, halted, illegal;
    logic [15:0] m_addr, m_wdata, m_rdata, pc;
    logic        w_req, w_we, w_ready, w_retired, w_halted, w_illegal;
    logic [19:0] w_addr, w_pc;
    logic [31:0] w_wdata, w_rdata;

    multicycle_core #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0000)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .mem_ready(m_ready),
        .pc(pc), .retired(retired), .halted(halted), .illegal(illegal)
    );

    multicycle_core #(.DATA_WIDTH(32), .ADDR_WIDTH(20), .RESET_PC(20'hFFFFF)) u_wide (
        .clock(clock), .reset_n(reset_n),
        .mem_req(w_req), .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .mem_rdata(w_rdata), .mem_ready(w_ready),
        .pc(w_pc), .retired(w_retired), .halted(w_halted), .illegal(w_illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory models; images are copied in from prog/wprog while load is high.
    logic [15:0] mem   [65536];
    logic [15:0] prog  [65536];
    logic [31:0] wmem  [256];
    logic [31:0] wprog [256];
    logic        load = 1'b0;
    int          stall_cnt;
    int          stall_need = 0;
    logic [15:0] stall_addr = 16'hFFFF;

    assign m_ready = m_req && ((m_addr != stall_addr) || (stall_cnt >= stall_need));
    assign m_rdata = mem[m_addr];
    assign w_ready = w_req;
    assign w_rdata = wmem[w_addr[7:0]];

    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= prog[i];
            for (int i = 0; i < 256; i++) wmem[i] <= wprog[i];
        end else begin
            if (m_req && m_ready && m_we) mem[m_addr] <= m_wdata;
            if (w_req && w_ready && w_we) wmem[w_addr[7:0]] <= w_wdata;
        end
        if (!reset_n) stall_cnt <= 0;
        else if (m_req) stall_cnt <= m_ready ? 0 : stall_cnt + 1;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observation of the narrow core, sampled on the falling edge.
    int          retire_q[$];
    logic [15:0] read_q[$];
    int          first_fetch = -1;
    int          stall_samples = 0;
    int          unstable = 0;
    logic        prev_stalled = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = '0, prev_wdata = '0;
    logic [19:0] w_first_addr = '0;
    logic        w_seen = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            retire_q.delete();
            read_q.delete();
            first_fetch   = -1;
            stall_samples = 0;
            unstable      = 0;
            prev_stalled  = 1'b0;
            w_seen        = 1'b0;
        end else begin
            if (retired) retire_q.push_back(cyc);
            if (m_req && m_ready && !m_we) read_q.push_back(m_addr);
            if (m_req && first_fetch < 0) first_fetch = cyc;
            if (prev_stalled && (m_req !== 1'b1 || m_we !== prev_we ||
                                 m_addr !== prev_addr || m_wdata !== prev_wdata))
                unstable++;
            if (m_req && !m_ready) stall_samples++;
            prev_stalled = m_req && !m_ready;
            prev_we      = m_we;
            prev_addr    = m_addr;
            prev_wdata   = m_wdata;
            if (w_req && !w_seen) begin
                w_first_addr = w_addr;
                w_seen       = 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic start_reset();
        @(negedge clock);
        reset_n = 1'b0;
        load    = 1'b1;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);
    endtask

    task automatic end_reset();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 65536; i++) prog[i] = 16'h0000;
    endtask

    task automatic wait_retires(input string tag, input int n, input int budget);
        int k = 0;
        while (retire_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(retire_q.size() >= n), 64'd1);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k = 0;
        while (!halted && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(halted), 64'd1);
    endtask

    initial begin
        logic [15:0] exp_fetch [12];
        int          req_hi;
        int          k;

        reset_n = 1'b0;
        for (int i = 0; i < 256; i++) wprog[i] = 32'h0;
        wprog[8'hFF] = 32'hDEAD_107F;   // addi r1,r0,-1 (upper half is junk)
        wprog[8'h00] = 32'hBEEF_3050;   // sw r1 -> mem[16]
        wprog[8'h01] = 32'h1234_F000;   // halt

        // Arithmetic, slt, wrap and r0 with zero-wait memory.
        clear_prog();
        prog[0]  = 16'h1045;  // addi r1,r0,5
        prog[1]  = 16'h10BD;  // addi r2,r0,-3
        prog[2]  = 16'h0298;  // add  r3,r1,r2
        prog[3]  = 16'h046E;  // slt  r5,r2,r1
        prog[4]  = 16'h11BF;  // addi r6,r0,-1
        prog[5]  = 16'h11C1;  // addi r7,r0,1
        prog[6]  = 16'h0DF0;  // add  r6,r6,r7
        prog[7]  = 16'h1007;  // addi r0,r0,7
        prog[8]  = 16'h3154;  // sw r5 -> 20
        prog[9]  = 16'h3195;  // sw r6 -> 21
        prog[10] = 16'h3016;  // sw r0 -> 22
        prog[11] = 16'h30D7;  // sw r3 -> 23
        prog[12] = 16'hF000;  // halt
        for (int i = 20; i < 24; i++) prog[i] = 16'hAAAA;
        start_reset();
        #1;
        check("rst_mem_req", 64'(m_req), 64'd0);
        check("rst_mem_we", 64'(m_we), 64'd0);
        check("rst_mem_addr", 64'(m_addr), 64'd0);
        check("rst_mem_wdata", 64'(m_wdata), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        end_reset();
        check("start_no_req", 64'(m_req), 64'd0);
        step();
        check("fetch_2nd_cycle_req", 64'(m_req), 64'd1);
        check("fetch_2nd_cycle_addr", 64'(m_addr), 64'd0);
        wait_retires("a_retire3_timeout", 3, 40);
        check("a_pc_after_3", 64'(pc), 64'd3);
        if (retire_q.size() >= 3) begin
            check("a_retire1_cycle", 64'(retire_q[0] - first_fetch + 1), 64'd4);
            check("a_retire2_cycle", 64'(retire_q[1] - first_fetch + 1), 64'd8);
            check("a_retire3_cycle", 64'(retire_q[2] - first_fetch + 1), 64'd12);
        end
        wait_halt("a_halt_timeout", 100);
        check("a_retire_count", 64'(retire_q.size()), 64'd12);
        check("a_slt", 64'(mem[20]), 64'd1);
        check("a_add_wrap", 64'(mem[21]), 64'd0);
        check("a_r0_stays_0", 64'(mem[22]), 64'd0);
        check("a_add_r3", 64'(mem[23]), 64'd2);

        // sw/lw with two wait states on each data access.
        clear_prog();
        prog[0]  = 16'h10C2;  // addi r3,r0,2
        prog[1]  = 16'h30CA;  // sw r3 -> 10
        prog[2]  = 16'h210A;  // lw r4 <- 10
        prog[3]  = 16'h310B;  // sw r4 -> 11
        prog[4]  = 16'hF000;  // halt
        prog[10] = 16'h5555;
        prog[11] = 16'h5555;
        stall_addr = 16'd10;
        stall_need = 2;
        start_reset();
        end_reset();
        wait_halt("b_halt_timeout", 100);
        check("b_retire_count", 64'(retire_q.size()), 64'd4);
        if (retire_q.size() >= 3) begin
            check("b_sw_latency", 64'(retire_q[1] - retire_q[0]), 64'd6);
            check("b_lw_latency", 64'(retire_q[2] - retire_q[1]), 64'd7);
        end
        check("b_stall_cycles", 64'(stall_samples), 64'd4);
        check("b_stable_during_stall", 64'(unstable), 64'd0);
        check("b_sw_data", 64'(mem[10]), 64'd2);
        check("b_lw_r4", 64'(mem[11]), 64'd2);
        stall_addr = 16'hFFFF;
        stall_need = 0;

        // Branches, jumps across the 12-bit page, and a self-loop.
        clear_prog();
        prog[16'h0000] = 16'h1045;  // addi r1,r0,5
        prog[16'h0004] = 16'h4242;  // beq r1,r1,+2 -> 7
        prog[16'h0007] = 16'h5245;  // bne r1,r1,+5 not taken -> 8
        prog[16'h0008] = 16'h6FFF;  // j 0xFFF
        prog[16'h1000] = 16'h6FFE;  // j 0xFFE -> 0x1FFE
        prog[16'h1FFE] = 16'h6123;  // j 0x123 with pc = 0x1FFF -> 0x1123
        prog[16'h1123] = 16'h403F;  // beq r0,r0,-1 loops here
        exp_fetch = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0007,
                      16'h0008, 16'h0FFF, 16'h1000, 16'h1FFE, 16'h1123, 16'h1123};
        start_reset();
        end_reset();
        wait_retires("c_retire_timeout", 12, 100);
        for (int i = 0; i < 12; i++)
            if (i < read_q.size()) check($sformatf("c_fetch_%0d", i), 64'(read_q[i]), 64'(exp_fetch[i]));
        if (retire_q.size() >= 12) begin
            check("c_beq_latency", 64'(retire_q[4] - retire_q[3]), 64'd3);
            check("c_loop_period", 64'(retire_q[11] - retire_q[10]), 64'd3);
        end
        check("c_not_halted", 64'(halted), 64'd0);

        // Illegal opcode, then reset recovery and an abandoned fetch.
        clear_prog();
        prog[0] = 16'hA000;
        start_reset();
        end_reset();
        wait_halt("d_halt_timeout", 20);
        check("d_illegal", 64'(illegal), 64'd1);
        check("d_no_retire", 64'(retire_q.size()), 64'd0);
        req_hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_req) req_hi++;
        end
        check("d_no_req_in_halt", 64'(req_hi), 64'd0);
        check("d_still_halted", 64'(halted), 64'd1);

        prog[0]    = 16'hF000;
        stall_addr = 16'h0000;
        stall_need = 1000;
        start_reset();
        #1;
        check("d_illegal_cleared", 64'(illegal), 64'd0);
        check("d_halted_cleared", 64'(halted), 64'd0);
        end_reset();
        step();
        step();
        check("d_refetch_req", 64'(m_req), 64'd1);
        check("d_refetch_addr", 64'(m_addr), 64'(16'h0000));
        reset_n = 1'b0;
        #1;
        check("d_async_drop_req", 64'(m_req), 64'd0);
        check("d_abandon_pc", 64'(pc), 64'd0);
        stall_need = 0;
        stall_addr = 16'hFFFF;
        end_reset();
        wait_halt("d2_halt_timeout", 20);
        check("d2_pc_after_halt", 64'(pc), 64'd1);

        // Wide core: runs its own program after every reset.
        k = 0;
        while (!w_halted && k < 50) begin
            step();
            k++;
        end
        check("w_halted", 64'(w_halted), 64'd1);
        check("w_first_fetch", 64'(w_first_addr), 64'(20'hFFFFF));
        check("w_pc_wrapped", 64'(w_pc), 64'd2);
        check("w_addi_minus1", 64'(wmem[16]), 64'(32'hFFFF_FFFF));
        check("w_illegal", 64'(w_illegal), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle successor to the 16-bit single-cycle processor. It executes the same 16-bit instruction format through a control FSM (START/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT) over one shared instruction/data memory port with a req/ready handshake, so memory may insert wait states. Datapath and address widths are generic. It sits between the testbench top and an external unified memory model.

## Interface
- DATA_WIDTH, 16, register/ALU/memory-word width; must be ≥ 16; instructions occupy bits [15:0] of a fetched word.
- ADDR_WIDTH, 16, word-address width of PC and memory port; must be ≥ 12.
- RESET_PC, 0, PC value loaded on reset.
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  1 = write (sw), 0 = read; valid while mem_req.
- mem_addr  out  ADDR_WIDTH  word address; valid while mem_req.
- mem_wdata  out  DATA_WIDTH  store data; valid while mem_req && mem_we.
- mem_rdata  in  DATA_WIDTH  read data; sampled on the edge where mem_req && mem_ready.
- mem_ready  in  1  access completes on any rising edge with mem_req && mem_ready; may be combinational from mem_req; ignored while mem_req = 0.
- pc  out  ADDR_WIDTH  current PC, registered.
- retired  out  1  one-cycle pulse in the final cycle of each completed instruction.
- halted  out  1  high in HALT state.
- illegal  out  1  sticky; set when an undefined opcode is decoded.

## Operation
- Fields: opcode [15:12], rs [11:9], rt [8:6], rd [5:3], funct [2:0], imm6 [5:0], sign-extended to DATA_WIDTH; jump target uses [11:0].
- Register file: 8 × DATA_WIDTH; r0 reads 0, and writes to r0 are discarded; all registers reset to 0.
- Opcodes:
  - 0000 R-type, rd = rs op rt. funct: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt (signed, result 0/1), 111 nop.
  - 0001 addi, rt = rs + imm.
  - 0010 lw, rt = mem[rs + imm].
  - 0011 sw, mem[rs + imm] = rt.
  - 0100 beq, 0101 bne: on taken, pc = pc + imm, where pc is already the incremented value.
  - 0110 j: pc = {pc[ADDR_WIDTH-1:12], instr[11:0]}.
  - 1111 halt.
  - Any other opcode: set illegal, go to HALT.
- Arithmetic wraps modulo 2^DATA_WIDTH. Memory address = low ADDR_WIDTH bits of rs + imm. PC wraps from 2^ADDR_WIDTH−1 to 0.
- FSM:
  - START: mem_req = 0; goes to FETCH next cycle.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On accept: IR ← mem_rdata[15:0], pc ← pc + 1, go to DECODE. Otherwise stay.
  - DECODE: latch A = R[rs], B = R[rt]. halt or illegal opcode → HALT; otherwise → EXECUTE.
  - EXECUTE:
    - R-type/addi: compute ALUOut → WRITEBACK.
    - lw/sw: compute address → MEMORY.
    - beq/bne/j: update pc, pulse retired → FETCH.
  - MEMORY: mem_req = 1, mem_addr = ALUOut, mem_we = (sw), mem_wdata = B. On accept: sw pulses retired → FETCH; lw latches MDR → WRITEBACK.
  - WRITEBACK: write ALUOut (rd for R-type, rt for addi) or MDR (rt for lw); pulse retired → FETCH.
  - HALT: mem_req = 0; stays until reset.
- Reset values: state START, pc = RESET_PC, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, retired 0, halted 0, illegal 0, IR/A/B/ALUOut/MDR 0.

## Timing
- Latency with zero wait states: branch/jump 3 cycles; R-type/addi 4; sw 4; lw 5. Each wait cycle in FETCH or MEMORY adds 1.
- First fetch request appears in the 2nd cycle after reset_n deasserts (START cycle first).
- mem_req, mem_we, mem_addr and mem_wdata are stable from request until acceptance.
- Reset asserted mid-access drops mem_req immediately (asynchronous); the access is abandoned and no register or PC update occurs.
- lw to r0: read is still performed; write is discarded.
- Taken branch to the current instruction (imm = −1) loops indefinitely; retired pulses every 3 cycles.

## Test plan
- Reset, zero-wait memory: addi r1,r0,5; addi r2,r0,−3; add r3,r1,r2 → r3 = 2; retired pulses at cycles 4, 8, 12 after the first fetch; pc = 3.
- sw r3 → mem[10]; lw r4 ← mem[10] with mem_ready held low 2 cycles in each access → r4 = 2; mem_req and mem_addr stable during the stall; lw takes 7 cycles.
- beq r1,r1,+2 from pc = 4 → next fetch address 7; bne on equal operands → next fetch 5; j 0x123 with pc = 0x1FFF → next fetch 0x1123.
- slt r5,r2,r1 (−3 < 5) → r5 = 1; add 0xFFFF + 1 → 0 (DATA_WIDTH = 16); write to r0 → r0 remains 0.
- Opcode 1010 → illegal = 1, halted = 1, mem_req stays 0 for 20 cycles; reset_n pulse → clears illegal and halted, fetch restarts at RESET_PC.
- DATA_WIDTH = 32, ADDR_WIDTH = 20: addi r1,r0,−1 → r1 = 0xFFFFFFFF; PC wrap 0xFFFFF → 0.
